// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 keypad column scanner with a 2-flop row synchroniser and
//               press/release debouncing. It drives one active-low column at
//               a time and freezes that column while a key is down. It emits
//               one key_press strobe per accepted press.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic [3:0] row_sync,
  output logic       key_press,
  output logic       key_busy
);

  localparam int c_DWELL_W = $clog2(SCAN_DIV);
  localparam int c_DB_W    = $clog2(DEBOUNCE);

  localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(SCAN_DIV - 1);
  localparam logic [c_DWELL_W-1:0] c_DWELL_ONE  = c_DWELL_W'(1);
  localparam logic [c_DB_W-1:0]    c_DB_LAST    = c_DB_W'(DEBOUNCE - 1);
  localparam logic [c_DB_W-1:0]    c_DB_ONE     = c_DB_W'(1);
  localparam logic [3:0]           c_IDLE       = 4'b1111;
  localparam logic [3:0]           c_COL_FIRST  = 4'b1110;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_t;

  state_t                r_state;
  logic [3:0]            r_row_s1;
  logic [3:0]            r_row_s2;
  logic [3:0]            r_col;
  logic [3:0]            r_pattern;
  logic [c_DWELL_W-1:0]  r_dwell;
  logic [c_DB_W-1:0]     r_db_cnt;
  logic                  r_key_press;
  logic                  r_key_busy;

  assign shift_col = r_col;
  assign row_sync  = r_row_s2;
  assign key_press = r_key_press;
  assign key_busy  = r_key_busy;

  // Two-flop synchroniser for the asynchronous row inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_s1 <= c_IDLE;
      r_row_s2 <= c_IDLE;
    end else begin
      r_row_s1 <= row;
      r_row_s2 <= r_row_s1;
    end
  end

  // Scan/debounce controller: column drive, counters, captured pattern, strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SCAN;
      r_col       <= c_COL_FIRST;
      r_pattern   <= c_IDLE;
      r_dwell     <= '0;
      r_db_cnt    <= '0;
      r_key_press <= 1'b0;
      r_key_busy  <= 1'b0;
    end else begin
      r_key_press <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          // Rows are only trusted at the end of the dwell, once the column settled
          if (r_dwell == c_DWELL_LAST) begin
            if (r_row_s2 == c_IDLE) begin
              r_col   <= {r_col[2:0], r_col[3]};
              r_dwell <= '0;
            end else begin
              r_pattern  <= r_row_s2;
              r_db_cnt   <= '0;
              r_state    <= ST_PRESS_DB;
              r_key_busy <= 1'b1;
            end
          end else begin
            r_dwell <= r_dwell + c_DWELL_ONE;
          end
        end

        ST_PRESS_DB: begin
          if (r_row_s2 == r_pattern) begin
            if (r_db_cnt == c_DB_LAST) begin
              r_state     <= ST_HELD;
              r_key_press <= 1'b1;
            end else begin
              r_db_cnt <= r_db_cnt + c_DB_ONE;
            end
          end else begin
            // Bounce: rescan the same column from the start of its dwell
            r_state    <= ST_SCAN;
            r_dwell    <= '0;
            r_key_busy <= 1'b0;
          end
        end

        ST_HELD: begin
          // Pattern changes while held are ignored; only a full release matters
          if (r_row_s2 == c_IDLE) begin
            r_state  <= ST_RELEASE_DB;
            r_db_cnt <= '0;
          end
        end

        ST_RELEASE_DB: begin
          if (r_row_s2 == c_IDLE) begin
            if (r_db_cnt == c_DB_LAST) begin
              r_state    <= ST_SCAN;
              r_dwell    <= '0;
              r_key_busy <= 1'b0;
            end else begin
              r_db_cnt <= r_db_cnt + c_DB_ONE;
            end
          end else begin
            r_state  <= ST_HELD;
            r_db_cnt <= '0;
          end
        end

        default: begin
          r_state    <= ST_SCAN;
          r_dwell    <= '0;
          r_key_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner (SCAN_DIV=4,
//               DEBOUNCE=8). It runs directed scenarios and then random row
//               activity. Both are compared every cycle against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;

  // Reference-model activity modes
  localparam int M_SCAN    = 0;
  localparam int M_PRESS   = 1;
  localparam int M_HELD    = 2;
  localparam int M_RELEASE = 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row   = 4'hF;
  logic [3:0] shift_col;
  logic [3:0] row_sync;
  logic       key_press;
  logic       key_busy;

  int total = 0;
  int bad   = 0;
  int dut_pulses = 0;

  // Reference model: column as an index, pipeline of sampled rows, run counters
  logic [3:0] m_s1;
  logic [3:0] m_sync;
  logic [3:0] m_pat;
  int         m_col;
  int         m_mode;
  int         m_dwell;
  int         m_run;
  logic       m_press;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .shift_col (shift_col),
    .row_sync  (row_sync),
    .key_press (key_press),
    .key_busy  (key_busy)
  );

  function automatic logic [3:0] col_drive(input int idx);
    logic [3:0] v;
    v = 4'hF;
    v[idx] = 1'b0;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1    = 4'hF;
    m_sync  = 4'hF;
    m_pat   = 4'hF;
    m_col   = 0;
    m_mode  = M_SCAN;
    m_dwell = 0;
    m_run   = 0;
    m_press = 1'b0;
  endtask

  // One clock of the keypad rules, using the synchronised row seen before the edge
  task automatic model_step();
    logic [3:0] seen;
    seen    = m_sync;
    m_press = 1'b0;
    if (m_mode == M_SCAN) begin
      if (m_dwell == SCAN_DIV - 1) begin
        if (seen == 4'hF) begin
          m_col   = (m_col + 1) % 4;
          m_dwell = 0;
        end else begin
          m_pat  = seen;
          m_run  = 0;
          m_mode = M_PRESS;
        end
      end else begin
        m_dwell++;
      end
    end else if (m_mode == M_PRESS) begin
      if (seen != m_pat) begin
        m_mode  = M_SCAN;
        m_dwell = 0;
      end else if (m_run == DEBOUNCE - 1) begin
        m_mode  = M_HELD;
        m_press = 1'b1;
      end else begin
        m_run++;
      end
    end else if (m_mode == M_HELD) begin
      if (seen == 4'hF) begin
        m_mode = M_RELEASE;
        m_run  = 0;
      end
    end else begin
      if (seen != 4'hF) begin
        m_mode = M_HELD;
        m_run  = 0;
      end else if (m_run == DEBOUNCE - 1) begin
        m_mode  = M_SCAN;
        m_dwell = 0;
      end else begin
        m_run++;
      end
    end
    m_sync = m_s1;
    m_s1   = row;
  endtask

  task automatic check_outputs();
    check("shift_col", shift_col, col_drive(m_col));
    check("row_sync", row_sync, m_sync);
    check("key_press", key_press, m_press);
    check("key_busy", key_busy, (m_mode != M_SCAN));
    if (key_press === 1'b1) dut_pulses++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    else       model_reset();
    #1;
    check_outputs();
  endtask

  task automatic wait_col(input logic [3:0] target, input int budget);
    int n;
    n = 0;
    while (shift_col !== target && n < budget) begin
      tick();
      n++;
    end
    check("wait_col", shift_col, target);
  endtask

  initial begin
    int t_press;
    int t_busy;
    int n;
    logic [3:0] v;
    logic [3:0] held_col;

    model_reset();
    reset = 1'b0;
    row   = 4'hF;

    // Reset state
    repeat (2) tick();
    check("rst_col", shift_col, 4'b1110);
    check("rst_sync", row_sync, 4'b1111);
    check("rst_press", key_press, 1'b0);
    check("rst_busy", key_busy, 1'b0);
    reset = 1'b1;

    // Idle scanning: each column for SCAN_DIV cycles, wrapping after 16
    dut_pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("idle_col", shift_col, col_drive((k / 4) % 4));
    end
    check("idle_pulses", dut_pulses, 0);

    // Clean press on column 1011
    wait_col(4'b1011, 20);
    row = 4'b1101;
    dut_pulses = 0;
    t_press = -1;
    t_busy  = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (key_press === 1'b1 && t_press < 0) t_press = i;
      if (key_busy === 1'b1 && t_busy < 0) t_busy = i;
    end
    check("press_busy_at", t_busy, 4);
    check("press_strobe_at", t_press, 12);
    check("press_pulses", dut_pulses, 1);
    check("press_col", shift_col, 4'b1011);
    check("press_busy", key_busy, 1'b1);

    // Release with a short glitch, then a clean release
    row = 4'hF;
    repeat (3) tick();
    row = 4'b1101;
    repeat (2) tick();
    row = 4'hF;
    repeat (24) tick();
    check("release_pulses", dut_pulses, 1);
    check("release_busy", key_busy, 1'b0);

    // Bouncing row: never stable long enough to accept
    dut_pulses = 0;
    for (int i = 0; i < 30; i++) begin
      row = ((i / 3) % 2 == 0) ? 4'b1101 : 4'hF;
      tick();
    end
    row = 4'hF;
    repeat (6) tick();
    check("bounce_pulses", dut_pulses, 0);
    check("bounce_busy", key_busy, 1'b0);

    // Reset pulse while a key is held
    repeat (4) tick();
    wait_col(4'b0111, 20);
    row = 4'b1110;
    n = 0;
    while (key_press !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("hold_strobe_seen", key_press, 1'b1);
    tick();
    check("hold_busy", key_busy, 1'b1);
    reset = 1'b0;
    row   = 4'hF;
    #1;
    model_reset();
    check("async_rst_col", shift_col, 4'b1110);
    check("async_rst_busy", key_busy, 1'b0);
    check("async_rst_press", key_press, 1'b0);
    tick();
    reset = 1'b1;
    dut_pulses = 0;
    repeat (40) tick();
    check("post_rst_pulses", dut_pulses, 0);

    // Long hold: one strobe, column frozen
    wait_col(4'b1101, 20);
    row = 4'b0111;
    dut_pulses = 0;
    repeat (20) tick();
    held_col = shift_col;
    repeat (980) tick();
    check("long_hold_col", shift_col, held_col);
    check("long_hold_col_val", held_col, 4'b1101);
    row = 4'hF;
    repeat (30) tick();
    check("long_hold_pulses", dut_pulses, 1);
    check("long_hold_busy", key_busy, 1'b0);

    // Random row activity against the reference model
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 3))
        0, 3: v = 4'hF;
        1: begin
          v = 4'hF;
          v[$urandom_range(0, 3)] = 1'b0;
        end
        default: v = 4'($urandom_range(0, 15));
      endcase
      row = v;
      repeat ($urandom_range(1, 25)) tick();
    end
    row = 4'hF;
    repeat (30) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
